alu_result_tx: RTL and testbench

- Return path of the ALU test system; it is the output end of the operand-load path.
- Captures one ALU result with its status flags on a valid/ready handshake.
- Serialises it as two back-to-back UART frames on a single TX line toward the host:
  - byte 0: the result
  - byte 1: the flags
- Sits between the ALU output and the board's UART TX pin. It generates its own bit timing, so no external baud tick is needed.

---
 rtl/alu_tx_pkg.sv | 18 +
 rtl/alu_result_tx_bit_timer.sv | 36 +++
 rtl/alu_result_tx.sv | 141 ++++++++++++++
 tb/tb_alu_result_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU result return path: state encoding, flag
// positions and the default bit period, also used by the matching UART receiver.
package alu_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;

   // 50 MHz system clock at 9600 baud
   localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/alu_result_tx_bit_timer.sv
// Free-running bit-period counter; o_tick marks the last cycle of each bit so
// the owner can advance on the same edge the counter wraps.
module bit_timer
   import alu_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: every combinational output gets a value on every path (here via the
   // if/else chain) so no latch is inferred.
   always_comb begin
      if (i_clear || (cnt_q == LAST)) cnt_d = '0;
      else                            cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from values sampled before the edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// Captures one ALU result plus flags and sends them as two back-to-back UART
// frames (result, then flags) on a registered, glitch-free TX line.
module alu_result_tx
   import alu_tx_pkg::*;
#(
   parameter int NB_DATA      = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int NB_STOP      = 1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_carry,
   input  logic               i_zero,
   output logic               o_ready,
   output logic               o_tx,
   output logic               o_done
);

   localparam int BIT_W = $clog2(NB_DATA);
   localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(NB_DATA - 1);
   localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(NB_STOP - 1);

   tx_state_e          state_q,    state_d;
   logic [BIT_W-1:0]   bit_idx_q,  bit_idx_d;
   logic               byte_idx_q, byte_idx_d;
   logic [NB_DATA-1:0] shift_q,    shift_d;
   logic [NB_DATA-1:0] flags_q,    flags_d;
   logic               tx_q,       tx_d;
   logic               ready_q,    ready_d;
   logic               done_q,     done_d;

   logic timer_tick;
   logic timer_clear;

   // Every state change (accept included) restarts the bit period.
   assign timer_clear = (state_d != state_q);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clear (timer_clear),
      .o_tick  (timer_tick)
   );

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      flags_d    = flags_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               shift_d             = i_result;
               flags_d             = '0;
               flags_d[FLAG_CARRY] = i_carry;
               flags_d[FLAG_ZERO]  = i_zero;
               byte_idx_d          = 1'b0;
               bit_idx_d           = '0;
               state_d             = START;
            end
         end
         START: begin
            if (timer_tick) begin
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (timer_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_DATA_BIT) begin
                  bit_idx_d = '0;
                  state_d   = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end
         STOP: begin
            if (timer_tick) begin
               if (bit_idx_q == LAST_STOP_BIT) begin
                  bit_idx_d = '0;
                  if (!byte_idx_q) begin
                     shift_d    = flags_q;
                     byte_idx_d = 1'b1;
                     state_d    = START;
                  end else begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         byte_idx_q <= 1'b0;
         shift_q    <= '0;
         flags_q    <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         flags_q    <= flags_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign o_tx    = tx_q;
   assign o_ready = ready_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx at 4 clocks per bit: every cycle of every
// frame is compared against the bit pattern expected from the sampled inputs.
module tb_alu_result_tx;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic [7:0] i_result;
   logic       i_carry;
   logic       i_zero;
   logic       o_ready;
   logic       o_tx;
   logic       o_done;

   int n_tests = 0;
   int n_fail  = 0;

   alu_result_tx #(
      .NB_DATA      (8),
      .CLKS_PER_BIT (4),
      .NB_STOP      (1)
   ) dut (
      .i_clock  (clk),
      .i_reset  (rst_n),
      .i_valid  (i_valid),
      .i_result (i_result),
      .i_carry  (i_carry),
      .i_zero   (i_zero),
      .o_ready  (o_ready),
      .o_tx     (o_tx),
      .o_done   (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on the negedge inside the first start-bit cycle; returns on the
   // negedge of the first cycle after the stop bit. With noise set, i_valid is
   // held high and the data inputs churn every cycle.
   task automatic check_frame(input string tag, input logic [7:0] b, input bit noise);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("%s tx bit%0d cyc%0d", tag, i, k), {15'd0, o_tx}, {15'd0, bits[i]});
            check($sformatf("%s busy bit%0d cyc%0d", tag, i, k), {14'd0, o_ready, o_done}, 16'd0);
            if (noise) begin
               i_valid  = 1'b1;
               i_result = 8'($urandom);
               i_carry  = 1'($urandom);
               i_zero   = 1'($urandom);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         check($sformatf("%s cyc%0d", tag, c), {13'd0, o_tx, o_ready, o_done}, 16'b110);
         @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] res, input logic carry, input logic zero);
      i_valid  = 1'b1;
      i_result = res;
      i_carry  = carry;
      i_zero   = zero;
      @(negedge clk);
      i_valid  = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_result = 8'h00;
      i_carry  = 1'b0;
      i_zero   = 1'b0;

      // Reset idle
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("in_reset cyc%0d", c), {13'd0, o_tx, o_ready, o_done}, 16'b110);
      end
      rst_n = 1'b1;
      check_idle("post_reset", 20);

      // Basic frame: A5 with carry=1, zero=0 -> flags byte 02
      send(8'hA5, 1'b1, 1'b0);
      check_frame("basic b0", 8'hA5, 1'b0);
      check_frame("basic b1", 8'h02, 1'b0);
      check("basic done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      check_idle("basic after", 5);

      // Input hold-off: i_valid and data churn for the whole transaction
      send(8'hA5, 1'b1, 1'b0);
      check_frame("holdoff b0", 8'hA5, 1'b1);
      check_frame("holdoff b1", 8'h02, 1'b1);
      i_valid = 1'b0;
      check("holdoff done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      check_idle("holdoff no_third", 20);

      // Back-to-back: second accept lands in the o_done cycle
      i_valid  = 1'b1;
      i_result = 8'h00;
      i_carry  = 1'b0;
      i_zero   = 1'b1;
      @(negedge clk);
      check_frame("b2b t0 b0", 8'h00, 1'b0);
      check_frame("b2b t0 b1", 8'h01, 1'b0);
      check("b2b t0 done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      check_frame("b2b t1 b0", 8'h00, 1'b0);
      check_frame("b2b t1 b1", 8'h01, 1'b0);
      i_valid = 1'b0;
      check("b2b t1 done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      check_idle("b2b after", 5);

      // Reset mid-frame during data bit 3 of byte 0 (bit 3 of 36 is 0)
      send(8'h36, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      check("midrst before", {14'd0, o_tx, o_ready}, 16'b00);
      #2 rst_n = 1'b0;
      #1 check("midrst async", {13'd0, o_tx, o_ready, o_done}, 16'b110);
      @(negedge clk);
      check("midrst held", {13'd0, o_tx, o_ready, o_done}, 16'b110);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("midrst after", 10);
      send(8'h3C, 1'b0, 1'b1);
      check_frame("midrst b0", 8'h3C, 1'b0);
      check_frame("midrst b1", 8'h01, 1'b0);
      check("midrst done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);

      // Boundary values
      send(8'hFF, 1'b1, 1'b1);
      check_frame("ones b0", 8'hFF, 1'b0);
      check_frame("ones b1", 8'h03, 1'b0);
      check("ones done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      send(8'h00, 1'b0, 1'b0);
      check_frame("zeros b0", 8'h00, 1'b0);
      check_frame("zeros b1", 8'h00, 1'b0);
      check("zeros done", {14'd0, o_done, o_ready}, 16'b11);
      @(negedge clk);
      check_idle("final", 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
